rgb_req_scheduler: RTL and testbench
====================================

// Module: rgb_req_scheduler
// PURPOSE
// Time-shares the single RGB status LED between N_REQ requesters (calc error, result-ready, busy, ...).
// Round-robin grant; each winner's colour shown for a fixed hold time, then a dark gap.
// color_out drives led_in of the RGB blink/driver stage; blink rate stays inside that stage.
// Sits between the calculator control logic and the LED driver.
// PARAMETERS
// N_REQ        4           number of requesters, >=2
// HOLD_CYCLES  50_000_000  clk_in cycles a granted colour is shown (0.5 s @100 MHz), >=1
// GAP_CYCLES   10_000_000  clk_in cycles of LED off after each hold, 0 = no gap state
// PORTS
// clk_in     in   1        system clock, 100 MHz
// reset      in   1        asynchronous, active-low reset (0 = reset)
// req        in   N_REQ    level request; requester holds high until its ack
// color      in   3*N_REQ  packed colours; slice i = color[3*i+:3]; bit2 blue, bit1 green, bit0 red
// abort      in   1        sync cancel of the current display
// ack        out  N_REQ    one-hot, 1-cycle pulse on the grant cycle
// grant_id   out  clog2(N) index of the current/last grantee
// busy       out  1        high in SHOW or GAP
// color_out  out  3        colour to the LED driver's led_in
// BEHAVIOUR
// - Reset (reset=0, async): state IDLE; ack=0, grant_id=0, busy=0, color_out=3'd0, rr pointer=0, counter=0.
// - FSM IDLE -> SHOW -> (GAP) -> IDLE. All outputs registered.
// - IDLE: if |req at edge k, pick a winner by round-robin, searching from (last_grant+1) mod N_REQ.
//   After reset the search starts at index 0.
//   At edge k: ack[w]=1 for exactly one cycle, grant_id=w, color_out=color[w] (sampled once at edge k), busy=1.
//   counter=HOLD_CYCLES-1; state moves to SHOW. Latency from req high in IDLE to ack/color is 1 cycle.
// - SHOW: color_out holds the latched colour; changes to color[] are ignored.
//   When counter==0: if GAP_CYCLES>0, go to GAP with counter=GAP_CYCLES-1 and color_out=0; else go to IDLE.
// - GAP: color_out=0, busy=1. When counter==0, go to IDLE with busy=0.
//   IDLE is always occupied for at least one cycle before the next grant.
// - Total display of one grant: HOLD_CYCLES cycles of colour, then GAP_CYCLES cycles off.
// - req dropped before ack: no grant, no record kept. req held after ack: treated as a new request (re-queued).
//   Pointer fairness bounds the wait to N_REQ-1 grants.
// - Colour 3'd0 is granted and shown as dark for the full hold.
// - abort=1 in SHOW/GAP: next cycle state IDLE, color_out=0, busy=0. rr pointer keeps the aborted grantee.
//   abort in IDLE takes priority over any req that cycle: no grant.
// - Reset mid-SHOW: immediate return to reset values; pointer back to 0.
// - Counter width = $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). Wrap-around is impossible: only load/decrement-to-0.
// - Assertions: ack is onehot0; ack!=0 only in the grant cycle; color_out==0 whenever !busy.
// STRUCTURE
// - rgb_pkg: typedef logic [2:0] rgb_t.
//   Constants RGB_OFF=3'b000, RGB_RED=3'b001, RGB_GREEN=3'b010, RGB_BLUE=3'b100.
//   typedef enum {S_IDLE,S_SHOW,S_GAP} sched_state_t.
// - Sub-module rr_arbiter #(N) (req, ptr -> onehot grant, index, valid); pure combinational.
//   Pointer register lives in rgb_req_scheduler.
// - rgb_req_scheduler: FSM, hold/gap counter, colour latch, output registers.
// TESTING  (N_REQ=4, HOLD_CYCLES=4, GAP_CYCLES=2)
// 1 Reset then req=4'b0010, color1=RGB_GREEN at edge 0
//   -> ack=4'b0010 at edge 1, color_out=3'b010 for 4 cycles, 0 for 2, busy=0 at edge 7.
// 2 req=4'b1111 held continuously, distinct colours
//   -> grant order 0,1,2,3,0; each ack 7 cycles apart; no requester granted twice before all served.
// 3 Grant req2 (RED), change color2 to BLUE during SHOW -> color_out stays 3'b001 for the full hold.
// 4 abort pulse on 2nd SHOW cycle -> next cycle color_out=0, busy=0, state IDLE.
//   Pending req1 is then granted 1 cycle later.
// 5 Async reset asserted mid-GAP (between clock edges)
//   -> outputs go to 0 immediately; after release, req=4'b1000 gives grant_id=3 (pointer back to 0).
// 6 GAP_CYCLES=0 rebuild, req=4'b0011 -> req0 shown 4 cycles, 1 IDLE cycle, req1 ack; color_out never stale.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared types and colour constants for the RGB status LED scheduler.
package rgb_pkg;

  typedef logic [2:0] rgb_t;

  localparam rgb_t RGB_OFF   = 3'b000;
  localparam rgb_t RGB_RED   = 3'b001;
  localparam rgb_t RGB_GREEN = 3'b010;
  localparam rgb_t RGB_BLUE  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP
  } sched_state_t;

endpackage

// File: rtl/rgb_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        idx      = IDX_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_req_scheduler.sv
// Time-shares one RGB LED between N_REQ requesters: round-robin grant, fixed hold, optional dark gap.
module rgb_req_scheduler
  import rgb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 10_000_000
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [3*N_REQ-1:0]       color,
  input  logic                     abort,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output rgb_t                     color_out,
  output sched_state_t             state_dbg
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Handshake: req is a level held until its one-cycle ack pulse; the ack cycle is the grant.
  sched_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [N_REQ-1:0] ack_n;
  logic [IDX_W-1:0] gid_n;
  logic             busy_n;
  rgb_t             col_n;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr       <= '0;
      ack       <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      color_out <= RGB_OFF;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ptr       <= ptr_n;
      ack       <= ack_n;
      grant_id  <= gid_n;
      busy      <= busy_n;
      color_out <= col_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    ack_n   = '0;
    gid_n   = grant_id;
    busy_n  = busy;
    col_n   = color_out;
    case (state)
      S_IDLE: begin
        if (!abort && arb_valid) begin
          state_n = S_SHOW;
          cnt_n   = CNT_W'(HOLD_CYCLES - 1);
          ack_n   = arb_grant;
          gid_n   = arb_idx;
          busy_n  = 1'b1;
          col_n   = color[3*int'(arb_idx) +: 3];
          ptr_n   = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      S_SHOW: begin
        if (abort || (cnt == '0 && GAP_CYCLES == 0)) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          col_n   = RGB_OFF;
        end else if (cnt == '0) begin
          state_n = S_GAP;
          cnt_n   = CNT_W'(GAP_CYCLES - 1);
          col_n   = RGB_OFF;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (abort || cnt == '0) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          col_n   = RGB_OFF;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
        col_n   = RGB_OFF;
      end
    endcase
  end

  assign state_dbg = state;

  // A grant always lands in SHOW with a freshly loaded hold count.
  a_ack_onehot : assert property (@(posedge clk_in) disable iff (!reset) $onehot0(ack));
  a_ack_grant  : assert property (@(posedge clk_in) disable iff (!reset)
                   (ack != '0) |-> (state == S_SHOW && cnt == CNT_W'(HOLD_CYCLES - 1)));
  a_dark_idle  : assert property (@(posedge clk_in) disable iff (!reset)
                   !busy |-> (color_out == RGB_OFF));

endmodule

// File: tb/tb_rgb_req_scheduler.sv
// Bench for rgb_req_scheduler: directed vectors, hand sequences and a randomized reference model.
module tb_rgb_req_scheduler;
  import rgb_pkg::*;

  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic         clk_in = 1'b0;
  logic         reset  = 1'b0;
  logic [3:0]   req_a = '0, req_b = '0;
  logic [11:0]  color_a = '0, color_b = '0;
  logic         abort_a = 1'b0, abort_b = 1'b0;
  logic [3:0]   ack_a, ack_b;
  logic [1:0]   gid_a, gid_b;
  logic         busy_a, busy_b;
  rgb_t         col_a, col_b;
  sched_state_t st_a, st_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per DUT (0: GAP=2, 1: GAP=0)
  bit         m_active[2];
  int         m_age[2];
  int         m_ptr[2];
  logic [1:0] m_gid[2];
  rgb_t       m_col[2];
  logic [3:0] e_ack[2];
  logic       e_busy[2];
  rgb_t       e_col[2];

  logic [1:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  rgb_req_scheduler #(.N_REQ(4), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut_a (
    .clk_in(clk_in), .reset(reset), .req(req_a), .color(color_a), .abort(abort_a),
    .ack(ack_a), .grant_id(gid_a), .busy(busy_a), .color_out(col_a), .state_dbg(st_a)
  );

  rgb_req_scheduler #(.N_REQ(4), .HOLD_CYCLES(HOLD), .GAP_CYCLES(0)) dut_b (
    .clk_in(clk_in), .reset(reset), .req(req_b), .color(color_b), .abort(abort_b),
    .ack(ack_b), .grant_id(gid_b), .busy(busy_b), .color_out(col_b), .state_dbg(st_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 0; m_age[d] = 0; m_ptr[d] = 0; m_gid[d] = '0; m_col[d] = RGB_OFF;
    end
  endtask

  // Display of one grant = ages 0..hold-1 coloured, hold..hold+gap-1 dark, idle at hold+gap.
  task automatic model_edge(input int d, input int gap, input logic [3:0] r,
                            input logic [11:0] c, input logic ab);
    int  win;
    bit  found;
    e_ack[d] = '0;
    if (m_active[d]) begin
      m_age[d]++;
      if (ab || m_age[d] >= HOLD + gap) m_active[d] = 0;
    end else if (!ab && r != '0) begin
      found = 0;
      win   = 0;
      for (int i = 0; i < 4; i++) begin
        if (!found && r[(m_ptr[d] + i) % 4]) begin
          found = 1;
          win   = (m_ptr[d] + i) % 4;
        end
      end
      m_active[d] = 1;
      m_age[d]    = 0;
      m_gid[d]    = 2'(win);
      m_col[d]    = c[3*win +: 3];
      m_ptr[d]    = (win + 1) % 4;
      e_ack[d]    = 4'(1 << win);
    end
    e_busy[d] = m_active[d];
    e_col[d]  = (m_active[d] && m_age[d] < HOLD) ? m_col[d] : RGB_OFF;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    req_a   = '0; req_b = '0; abort_a = 1'b0; abort_b = 1'b0;
    repeat (2) tick();
    check("reset_ack",   {28'd0, ack_a}, 32'd0);
    check("reset_state", {23'd0, gid_a, busy_a, col_a, st_a}, 32'd0);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic wait_idle_a(input int bound);
    bit done;
    done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      if (!busy_a) done = 1;
      else tick();
    end
    check("wait_idle", {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] ack;
    logic       busy;
    rgb_t       col;
  } vec_t;

  initial begin
    vec_t vt[8];
    int   t, last_t, grants;
    logic [1:0] e;

    // Test 1: single grant, full hold then gap
    vt[0] = '{4'b0010, 4'b0010, 1'b1, RGB_GREEN};
    vt[1] = '{4'b0000, 4'b0000, 1'b1, RGB_GREEN};
    vt[2] = '{4'b0000, 4'b0000, 1'b1, RGB_GREEN};
    vt[3] = '{4'b0000, 4'b0000, 1'b1, RGB_GREEN};
    vt[4] = '{4'b0000, 4'b0000, 1'b1, RGB_OFF};
    vt[5] = '{4'b0000, 4'b0000, 1'b1, RGB_OFF};
    vt[6] = '{4'b0000, 4'b0000, 1'b0, RGB_OFF};
    vt[7] = '{4'b0000, 4'b0000, 1'b0, RGB_OFF};
    do_reset();
    color_a = {RGB_BLUE, RGB_RED, RGB_GREEN, RGB_BLUE};
    for (int i = 0; i < 8; i++) begin
      req_a = vt[i].req;
      tick();
      check($sformatf("t1_ack[%0d]", i),  {28'd0, ack_a}, {28'd0, vt[i].ack});
      check($sformatf("t1_busy[%0d]", i), {31'd0, busy_a}, {31'd0, vt[i].busy});
      check($sformatf("t1_col[%0d]", i),  {29'd0, col_a}, {29'd0, vt[i].col});
      check($sformatf("t1_gid[%0d]", i),  {30'd0, gid_a}, 32'd1);
    end

    // Test 2: all requesting, round-robin order and 7-cycle spacing
    do_reset();
    color_a = {RGB_BLUE, RGB_GREEN, RGB_RED, 3'b111};
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req_a = 4'hf;
    t = 0; last_t = -1; grants = 0;
    while (grants < 5 && t < 80) begin
      tick();
      t++;
      if (ack_a != '0) begin
        e = exp_q.pop_front();
        check("rr_gid", {30'd0, gid_a}, {30'd0, e});
        check("rr_ack", {28'd0, ack_a}, 32'(1 << e));
        check("rr_col", {29'd0, col_a}, {29'd0, color_a[3*int'(e) +: 3]});
        if (last_t >= 0) check("rr_spacing", 32'(t - last_t), 32'd7);
        last_t = t;
        grants++;
      end
    end
    check("rr_grants", 32'(grants), 32'd5);
    req_a = '0;

    // Test 3: colour latched at the grant edge
    do_reset();
    color_a = {RGB_OFF, RGB_RED, RGB_OFF, RGB_OFF};
    req_a = 4'b0100;
    tick();
    check("t3_ack", {28'd0, ack_a}, 32'b0100);
    req_a = '0;
    color_a = {RGB_OFF, RGB_BLUE, RGB_OFF, RGB_OFF};
    check("t3_col0", {29'd0, col_a}, {29'd0, RGB_RED});
    for (int i = 1; i < HOLD; i++) begin
      tick();
      check($sformatf("t3_col%0d", i), {29'd0, col_a}, {29'd0, RGB_RED});
    end
    wait_idle_a(20);

    // Test 4: abort in the second SHOW cycle, pending req1 granted one cycle later
    do_reset();
    color_a = {RGB_OFF, RGB_OFF, RGB_BLUE, RGB_GREEN};
    req_a = 4'b0011;
    tick();
    check("t4_ack0", {28'd0, ack_a}, 32'b0001);
    req_a = 4'b0010;
    tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("t4_abort", {27'd0, ack_a, busy_a}, 32'd0);
    check("t4_dark",  {29'd0, col_a}, 32'd0);
    check("t4_idle",  {30'd0, st_a}, {30'd0, S_IDLE});
    tick();
    check("t4_ack1", {28'd0, ack_a}, 32'b0010);
    check("t4_gid1", {30'd0, gid_a}, 32'd1);
    check("t4_col1", {29'd0, col_a}, {29'd0, RGB_BLUE});
    req_a = '0;
    wait_idle_a(20);

    // Test 5: async reset mid-GAP, pointer returns to 0
    do_reset();
    color_a = {RGB_RED, RGB_OFF, RGB_OFF, RGB_GREEN};
    req_a = 4'b0001;
    tick();
    req_a = '0;
    repeat (HOLD) tick();
    check("t5_in_gap", {28'd0, busy_a, col_a}, {28'd0, 1'b1, RGB_OFF});
    #2 reset = 1'b0;
    #1;
    check("t5_async", {23'd0, ack_a, gid_a, busy_a, col_a}, 32'd0);
    check("t5_state", {30'd0, st_a}, {30'd0, S_IDLE});
    tick();
    reset = 1'b1;
    req_a = 4'b1000;
    tick();
    check("t5_gid3", {30'd0, gid_a}, 32'd3);
    req_a = '0;
    wait_idle_a(20);
    do_reset();
    req_a = 4'b1001;
    tick();
    check("t5_ptr0", {30'd0, gid_a}, 32'd0);
    req_a = '0;
    wait_idle_a(20);

    // Test 6: no-gap build, one IDLE cycle between grants
    do_reset();
    color_b = {RGB_OFF, RGB_OFF, RGB_BLUE, RGB_RED};
    req_b = 4'b0011;
    tick();
    check("t6_ack0", {28'd0, ack_b}, 32'b0001);
    check("t6_col0", {29'd0, col_b}, {29'd0, RGB_RED});
    req_b = 4'b0010;
    for (int i = 1; i < HOLD; i++) begin
      tick();
      check($sformatf("t6_hold%0d", i), {28'd0, busy_b, col_b}, {28'd0, 1'b1, RGB_RED});
    end
    tick();
    check("t6_idle", {27'd0, ack_b, busy_b, col_b}, 32'd0);
    tick();
    check("t6_ack1", {28'd0, ack_b}, 32'b0010);
    check("t6_col1", {29'd0, col_b}, {29'd0, RGB_BLUE});
    req_b = '0;

    // Randomized run against the reference model, both builds
    do_reset();
    for (int n = 0; n < 600; n++) begin
      req_a   = 4'($urandom_range(0, 15));
      color_a = 12'($urandom);
      abort_a = ($urandom_range(0, 19) == 0);
      req_b   = req_a;
      color_b = color_a;
      abort_b = abort_a;
      tick();
      model_edge(0, GAP, req_a, color_a, abort_a);
      model_edge(1, 0,   req_b, color_b, abort_b);
      check($sformatf("rnd_a[%0d]", n), {23'd0, ack_a, gid_a, busy_a, col_a},
            {23'd0, e_ack[0], m_gid[0], e_busy[0], e_col[0]});
      check($sformatf("rnd_b[%0d]", n), {23'd0, ack_b, gid_b, busy_b, col_b},
            {23'd0, e_ack[1], m_gid[1], e_busy[1], e_col[1]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
